// File: rtl/servant_uart_tx.sv
// servant_uart_tx: 8N1 UART transmitter with a small byte FIFO in front.
// Bytes enter on a valid/ready handshake and leave LSB-first on a line that idles high.
module servant_uart_tx #(
  parameter int CLKS_PER_BIT = 280,
  parameter int DEPTH        = 4
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy
);

  // state | meaning
  // IDLE  | line high, waiting for the FIFO to hold a byte
  // START | start bit (low) for one bit period
  // DATA  | eight data bits, LSB first, shift register moves right per bit
  // STOP  | stop bit (high); chains straight into START if more bytes wait
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       baud_done;
  logic [7:0] head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push      = i_valid && !full;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign baud_done = (baud_q == BAUD_LAST);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = i_data;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // tx_d is the line level for the cycle after the edge, so o_tx comes straight off a flop.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign o_tx    = tx_q;
  assign o_ready = !full;
  assign o_busy  = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_servant_uart_tx.sv
// Bench for servant_uart_tx: a frame-schedule reference model predicts line, ready and busy
// every cycle, and a bench-side UART decoder recovers the transmitted bytes.
module tb_servant_uart_tx;
  localparam int CPB   = 28;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       wb_clk   = 1'b0;
  logic       wb_rst_n = 1'b1;
  logic [7:0] i_data   = 8'h00;
  logic       i_valid  = 1'b0;
  logic       o_ready;
  logic       o_tx;
  logic       o_busy;

  servant_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_tx    (o_tx),
    .o_busy  (o_busy)
  );

  always #5 wb_clk = ~wb_clk;

  int total = 0;
  int bad   = 0;
  int e     = 0;

  // Model: each accepted byte gets an acceptance edge, a start edge and an end edge.
  int         m_acc[$];
  int         m_start[$];
  int         m_end[$];
  logic [7:0] m_data[$];
  int         prev_end = 0;

  logic       d_busy = 1'b0;
  int         d_start = 0;
  logic [9:0] d_bits = '0;
  logic [7:0] rx[$];
  int         falls[$];
  int         last_busy_drop = -1;
  logic       prev_busy = 1'b0;

  function automatic int occ();
    int n = 0;
    foreach (m_acc[i]) begin
      if (m_acc[i] <= e) n++;
      if (m_start[i] <= e) n--;
    end
    return n;
  endfunction

  function automatic logic tx_model();
    foreach (m_start[i]) begin
      if (m_start[i] <= e && e < m_end[i]) begin
        int b;
        b = (e - m_start[i]) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_data[i][b-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic busy_model();
    return (m_end.size() > 0) && (m_end[$] > e);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, e, got, exp);
      if (bad >= 25) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  endtask

  task automatic clear_model();
    m_acc.delete();
    m_start.delete();
    m_end.delete();
    m_data.delete();
    prev_end = 0;
    d_busy   = 1'b0;
  endtask

  task automatic tick();
    logic acc;
    int   s;
    int   k;
    acc = i_valid && wb_rst_n && (occ() < DEPTH);
    @(posedge wb_clk);
    e++;
    if (acc) begin
      s = (e + 1 > prev_end) ? e + 1 : prev_end;
      m_acc.push_back(e);
      m_start.push_back(s);
      m_end.push_back(s + FRAME);
      m_data.push_back(i_data);
      prev_end = s + FRAME;
    end
    #1;
    check("tx", {31'b0, o_tx}, {31'b0, tx_model()});
    check("ready", {31'b0, o_ready}, {31'b0, (occ() < DEPTH)});
    check("busy", {31'b0, o_busy}, {31'b0, busy_model()});
    if (prev_busy && !o_busy) last_busy_drop = e;
    prev_busy = o_busy;
    if (!wb_rst_n) begin
      d_busy = 1'b0;
    end else if (d_busy) begin
      k = e - d_start;
      if (k % CPB == CPB / 2) begin
        d_bits[k / CPB] = o_tx;
        if (k / CPB == 9) begin
          d_busy = 1'b0;
          rx.push_back(d_bits[8:1]);
          check("stop_bit", {31'b0, d_bits[9]}, 32'd1);
        end
      end
    end else if (o_tx === 1'b0) begin
      d_busy  = 1'b1;
      d_start = e;
      falls.push_back(e);
    end
  endtask

  task automatic push(input logic [7:0] b, output int acc_e);
    int n0;
    n0      = m_acc.size();
    i_valid = 1'b1;
    i_data  = b;
    for (int k = 0; k < 20 * FRAME && m_acc.size() == n0; k++) tick();
    i_valid = 1'b0;
    acc_e   = (m_acc.size() > n0) ? m_acc[$] : -1;
  endtask

  task automatic drain();
    while (m_end.size() > 0 && e < m_end[$] + CPB) tick();
    repeat (4) tick();
  endtask

  task automatic expect_rx(input string tag, input logic [7:0] b, output logic [7:0] got);
    got = 8'hxx;
    if (rx.size() > 0) got = rx.pop_front();
    check(tag, {24'b0, got}, {24'b0, b});
  endtask

  task automatic do_reset();
    #3;
    wb_rst_n = 1'b0;
    clear_model();
    #1;
    check("rst_tx", {31'b0, o_tx}, 32'd1);
    check("rst_ready", {31'b0, o_ready}, 32'd1);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    repeat (3) tick();
    wb_rst_n = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    int         a;
    int         a2;
    int         f;
    int         n0;
    logic [7:0] b;
    logic [7:0] got;
    logic [7:0] exp_q[$];
    string      msg;

    #2;
    do_reset();

    // single byte: latency, bit timing, busy release
    falls.delete();
    push(8'h55, a);
    drain();
    f = (falls.size() > 0) ? falls[0] : -1;
    check("t1_fall_latency", f, a + 1);
    check("t1_busy_drop", last_busy_drop, a + 1 + FRAME);
    expect_rx("t1_byte", 8'h55, got);

    // back-to-back frames with no idle gap
    falls.delete();
    push(8'h00, a);
    push(8'hFF, a2);
    drain();
    f = (falls.size() > 1) ? falls[1] : -1;
    check("t2_second_start", f, a + 1 + FRAME);
    check("t2_busy_drop", last_busy_drop, a + 1 + 2 * FRAME);
    expect_rx("t2_byte0", 8'h00, got);
    expect_rx("t2_byte1", 8'hFF, got);

    // FIFO full: valid held with 0x41.. ; only five bytes fit
    i_valid = 1'b1;
    i_data  = 8'h41;
    for (int k = 0; k < 8; k++) begin
      n0 = m_acc.size();
      tick();
      if (m_acc.size() > n0) i_data = i_data + 8'd1;
    end
    check("t3_ready_full", {31'b0, o_ready}, 32'd0);
    i_valid = 1'b0;
    drain();
    for (int k = 0; k < 5; k++) expect_rx("t3_order", 8'h41 + 8'(k), got);
    check("t3_extra", rx.size(), 0);

    // pointer wrap-around
    for (int k = 0; k < 20; k++) push(8'(k), a);
    drain();
    for (int k = 0; k < 20; k++) expect_rx("t4_wrap", 8'(k), got);
    check("t4_extra", rx.size(), 0);

    // reset during data bit 3, with a second byte waiting in the FIFO
    push(8'hA5, a);
    push(8'h77, a2);
    while (e < a + 1 + 4 * CPB + CPB / 2) tick();
    do_reset();
    rx.delete();
    check("t5_busy_after", {31'b0, o_busy}, 32'd0);
    push(8'h3C, a);
    drain();
    expect_rx("t5_clean", 8'h3C, got);
    check("t5_extra", rx.size(), 0);

    // console text
    msg = "Hi\n";
    for (int k = 0; k < msg.len(); k++) push(msg[k], a);
    drain();
    for (int k = 0; k < msg.len(); k++) begin
      expect_rx("t6_text", msg[k], got);
      $write("%c", got);
    end

    // random bytes with random gaps
    for (int k = 0; k < 25; k++) begin
      b = 8'($urandom);
      push(b, a);
      exp_q.push_back(b);
      repeat ($urandom_range(0, 12 * CPB)) tick();
    end
    drain();
    foreach (exp_q[k]) expect_rx("t7_rand", exp_q[k], got);
    check("t7_extra", rx.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/servant_uart_tx.md
Name: servant_uart_tx

Overview:
- Synthesizable 8N1 UART transmitter: the sending end of the serial link that the bench-side UART decoder listens to.
- Accepts bytes over a valid/ready handshake into a small FIFO and serializes them LSB-first on a single line that idles high.
- Used as a console-output peripheral for the servant SoC, and as a serial stimulus source in simulation.

Parameters:
CLKS_PER_BIT, 280, clock cycles per bit period (16.13 MHz / 57600 baud); legal range >= 2.
DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
wb_clk  input  1  system clock; all logic on its rising edge.
wb_rst_n  input  1  asynchronous, active-low reset.
i_data  input  8  byte to transmit.
i_valid  input  1  i_data is valid.
o_ready  output  1  FIFO can accept a byte; equals !full.
o_tx  output  1  serial line out; idles high.
o_busy  output  1  high while the FIFO is non-empty or a frame is in progress.

Behaviour:
- Reset (wb_rst_n low, asynchronous):
  - o_tx=1, o_ready=1, o_busy=0.
  - FIFO is flushed; FSM goes to IDLE; baud and bit counters clear.
  - Reset mid-frame aborts the frame: line returns high immediately, without waiting for a clock edge.
- Handshake:
  - A byte is written on any rising edge where i_valid && o_ready.
  - If full, i_valid is ignored and data is not latched, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full: count is unchanged and data order is preserved.
- FIFO: DEPTH entries; read/write pointers are log2(DEPTH)+1 bits wide and wrap naturally.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_tx=1. If the FIFO is non-empty, pop into the 8-bit shift register and go to START. o_tx falls on the edge after the byte's write edge when idle and empty, so latency is 1 cycle from acceptance to start bit.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_tx = shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit 7, go to STOP.
  - STOP: o_tx=1 for exactly CLKS_PER_BIT cycles. At the end of the stop bit:
    - FIFO non-empty: pop and go directly to START, so there is no idle gap between frames.
    - FIFO empty: go to IDLE.
- Frame timing:
  - One frame = 10*CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and reloads at the bit boundary; no drift accumulates.
- Output registration: o_tx comes from a flop (glitch-free). o_busy and o_ready are combinational from registered state.
- o_busy = (state != IDLE) || !empty.

Test Plan:
- Single byte, timing: reset, push 0x55 once → o_tx falls 1 cycle after acceptance. Line reads 0,1,0,1,0,1,0,1,0,1 with each bit exactly 280 cycles. o_busy drops when the stop bit ends, 2800 cycles after the fall.
- Back-to-back: push 0x00 then 0xFF → the second start bit follows the first stop bit with no gap. Low run of 9*280, high 280, low 280, then high.
- FIFO full: hold i_valid with 0x41..0x46 from idle → exactly 5 bytes accepted (1 in the shift register + 4 in the FIFO), then o_ready=0. Bytes 0x41..0x45 are transmitted in order; o_ready re-asserts after the first pop following the 0x41 frame.
- Wrap-around: push 20 bytes 0x00..0x13 via the handshake → all decoded in order, with no loss or duplication.
- Reset mid-frame: assert wb_rst_n=0 during DATA bit 3 of 0xA5 → o_tx=1 without a clock edge, FIFO is empty, o_busy=0. After release, pushing 0x3C yields a clean frame.
- Loopback: connect o_tx to the bench UART decoder at 57600 baud, push "Hi\n" → decoder prints "Hi" and a newline.
